// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU constants: datapath widths, the canonical NOP and the
// bit positions of the branch immediate fields.
package cpu_pkg;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
endpackage

// File: rtl/branch_target.sv
// Branch target adder: sign-extends the B (imm26) or CB (imm19) word offset,
// scales it to bytes and adds it to the branch PC with wrap-around.
module branch_target
  import cpu_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [AW-1:0]      pc,
  input  logic               uncond_br,
  output logic [AW-1:0]      target
);
  localparam int W26 = IMM26_MSB - IMM26_LSB + 1;
  localparam int W19 = IMM19_MSB - IMM19_LSB + 1;

  logic [W26-1:0] imm26;
  logic [W19-1:0] imm19;
  logic [AW-1:0]  offset;
  logic           unused_opcode_bits;

  assign imm26 = instr[IMM26_MSB:IMM26_LSB];
  assign imm19 = instr[IMM19_MSB:IMM19_LSB];
  // Opcode bits are decoded elsewhere; only the immediate matters here.
  assign unused_opcode_bits = ^instr[INSTR_W-1:IMM26_MSB+1];

  always_comb begin
    offset = '0;
    if (uncond_br) offset = {{(AW-W26){imm26[W26-1]}}, imm26};
    else           offset = {{(AW-W19){imm19[W19-1]}}, imm19};
  end

  assign target = pc + (offset << 2);
endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID pipeline register and
// taken-branch redirect. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic                 uncond_br,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   if_id_instr,
  output logic [ADDR_W-1:0]    if_id_pc,
  output logic                 if_id_valid,
  output logic                 redirect,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_redirect_cnt
);
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0]  br_target;
  logic               load_word;

  branch_target #(.AW(ADDR_W)) u_branch_target (
    .instr     (if_id_instr_q),
    .pc        (if_id_pc_q),
    .uncond_br (uncond_br),
    .target    (br_target)
  );

  // if_id_valid_q low is the one-bubble squash state; stall is the hold state.
  assign redirect  = br_taken & if_id_valid_q & ~stall;
  assign load_word = ~stall & ~redirect;

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if (redirect) begin
      pc_d          = br_target;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (load_word) begin
      pc_d          = pc_q + ADDR_W'(4);
      if_id_instr_d = imem_rdata;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (load_word && (fetch_cnt_q != 32'hFFFF_FFFF))   fetch_cnt_d    = fetch_cnt_q + 32'd1;
    if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`else
  assign perf_fetch_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, B/CB redirects,
// stall priority, PC wrap and perf counters (zero when the feature is off).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hD503201F;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] EXP_FETCH = 32'd5;
  localparam logic [31:0] EXP_REDIR = 32'd1;
`else
  localparam logic [31:0] EXP_FETCH = 32'd0;
  localparam logic [31:0] EXP_REDIR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic        uncond_br = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
  logic        redirect;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redirect_cnt;

  logic        use_force = 1'b0;
  logic [31:0] force_word = 32'h0;
  int          passed = 0;
  int          total = 0;
  int          failed = 0;

  fetch_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall             (stall),
    .br_taken          (br_taken),
    .uncond_br         (uncond_br),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .if_id_instr       (if_id_instr),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .redirect          (redirect),
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: word = (0xAAAA0000 + addr[31:0]) ^ addr[63:32], unless overridden.
  assign imem_rdata = use_force ? force_word
                                : ((32'hAAAA0000 + imem_addr[31:0]) ^ imem_addr[63:32]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    br_taken = 1'b1;
    #11;
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    chk("rst_pc", if_id_pc, 64'h0);
    chk("rst_valid", {63'h0, if_id_valid}, 64'h0);
    chk("rst_redirect", {63'h0, redirect}, 64'h0);
    chk("rst_perf_f", {32'h0, perf_fetch_cnt}, 64'h0);
    br_taken = 1'b0;
    reset_n = 1'b1;

    // First fetch
    step();
    chk("f1_instr", {32'h0, if_id_instr}, 64'hAAAA0000);
    chk("f1_pc", if_id_pc, 64'h0);
    chk("f1_valid", {63'h0, if_id_valid}, 64'h1);
    chk("f1_addr", imem_addr, 64'h4);

    // B imm26=3 at pc 8 -> target 20
    step();
    use_force = 1'b1; force_word = 32'h14000003;
    step();
    use_force = 1'b0;
    chk("b_ifid", {32'h0, if_id_instr}, 64'h14000003);
    br_taken = 1'b1; uncond_br = 1'b1;
    #1;
    chk("b_redirect", {63'h0, redirect}, 64'h1);
    step();
    chk("b_addr", imem_addr, 64'd20);
    chk("b_valid", {63'h0, if_id_valid}, 64'h0);
    chk("b_nop", {32'h0, if_id_instr}, {32'h0, NOP});
    chk("b_pc_kept", if_id_pc, 64'h8);
    chk("b_squash_ignored", {63'h0, redirect}, 64'h0);
    br_taken = 1'b0;
    step();
    chk("b_target_word", {32'h0, if_id_instr}, 64'hAAAA0014);
    chk("b_target_pc", if_id_pc, 64'd20);

    // CBZ imm19=0x7FFFE at pc 0x10 -> target 0x08
    do_reset();
    repeat (4) step();
    chk("cb_addr_pre", imem_addr, 64'h10);
    use_force = 1'b1; force_word = 32'hB4FFFFC0;
    step();
    use_force = 1'b0;
    br_taken = 1'b1; uncond_br = 1'b0;
    #1;
    chk("cb_redirect", {63'h0, redirect}, 64'h1);
    step();
    chk("cb_addr", imem_addr, 64'h8);
    br_taken = 1'b0;

    // Stall beats redirect: B imm26=4 at pc 8 held for 3 cycles
    use_force = 1'b1; force_word = 32'h14000004;
    step();
    use_force = 1'b0;
    stall = 1'b1; br_taken = 1'b1; uncond_br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_redirect", {63'h0, redirect}, 64'h0);
      step();
      chk("st_addr", imem_addr, 64'hC);
      chk("st_pc", if_id_pc, 64'h8);
      chk("st_instr", {32'h0, if_id_instr}, 64'h14000004);
      chk("st_valid", {63'h0, if_id_valid}, 64'h1);
    end
    stall = 1'b0;
    #1;
    chk("st_release_redirect", {63'h0, redirect}, 64'h1);
    step();
    chk("st_target", imem_addr, 64'd24);
    br_taken = 1'b0;

    // B imm26=-1 at pc 0 -> 2^64-4, then sequential fetch wraps to 0
    do_reset();
    use_force = 1'b1; force_word = 32'h17FFFFFF;
    step();
    use_force = 1'b0;
    br_taken = 1'b1; uncond_br = 1'b1;
    #1;
    step();
    chk("neg_target", imem_addr, TOP_PC);
    br_taken = 1'b0;
    step();
    chk("wrap_pc", if_id_pc, TOP_PC);
    chk("wrap_instr", {32'h0, if_id_instr}, 64'h55560003);
    chk("wrap_addr", imem_addr, 64'h0);

    // Two stall cycles, then three more fetches: 5 loads, 1 redirect since reset
    stall = 1'b1;
    repeat (2) step();
    chk("perf_stall_addr", imem_addr, 64'h0);
    stall = 1'b0;
    repeat (3) step();
    chk("perf_addr", imem_addr, 64'hC);
    chk("perf_fetch", {32'h0, perf_fetch_cnt}, {32'h0, EXP_FETCH});
    chk("perf_redir", {32'h0, perf_redirect_cnt}, {32'h0, EXP_REDIR});

    // Reset while a redirect is pending clears everything immediately
    br_taken = 1'b1;
    #1;
    chk("pend_redirect", {63'h0, redirect}, 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_redirect", {63'h0, redirect}, 64'h0);
    chk("mid_rst_addr", imem_addr, 64'h0);
    chk("mid_rst_valid", {63'h0, if_id_valid}, 64'h0);
    chk("mid_rst_perf_f", {32'h0, perf_fetch_cnt}, 64'h0);
    chk("mid_rst_perf_r", {32'h0, perf_redirect_cnt}, 64'h0);
    br_taken = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_instr", {32'h0, if_id_instr}, 64'hAAAA0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the LEGv8 pipelined CPU, directly upstream of the control-signal decoder. Holds the program counter, drives the instruction-memory address, and captures the returned word plus its PC into the IF/ID pipeline register consumed by decode. Resolves taken branches from the decoder's BrTaken/UncondBr outputs by computing the target from the instruction held in IF/ID, redirecting the PC and squashing the wrong-path fetch.

## Interface
- ADDR_W, 64, PC/address width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- stall  input  1  hold PC and IF/ID (load-use hazard from downstream)
- br_taken  input  1  decoder BrTaken for instruction currently in IF/ID
- uncond_br  input  1  decoder UncondBr: 1 = B (imm26), 0 = CB-type (imm19)
- imem_addr  output  ADDR_W  fetch address, equals PC register
- imem_rdata  input  32  instruction word, combinational read of imem_addr
- if_id_instr  output  32  instruction to decode
- if_id_pc  output  ADDR_W  PC of if_id_instr
- if_id_valid  output  1  if_id_instr is a real instruction
- redirect  output  1  combinational: branch taken this cycle, fetch squashed
- perf_fetch_cnt  output  32  fetched-instruction count (FETCH_PERF_CNT_EN only)
- perf_redirect_cnt  output  32  taken-branch count (FETCH_PERF_CNT_EN only)

## Operation
- redirect = br_taken & if_id_valid & ~stall; br_taken is ignored when IF/ID is invalid or stalled.
- Branch offset: uncond_br=1 → sign-extend if_id_instr[25:0]; uncond_br=0 → sign-extend if_id_instr[23:5]; offset shifted left 2, added to if_id_pc, modulo 2^ADDR_W (wrap, no trap).
- Per rising edge, priority order:
  - stall=1: PC, if_id_* unchanged (stall beats redirect).
  - redirect=1: PC ← target; if_id_valid ← 0; if_id_instr ← NOP (32'hD503201F); if_id_pc unchanged.
  - otherwise: PC ← PC+4 (wraps); if_id_instr ← imem_rdata; if_id_pc ← PC; if_id_valid ← 1.
- Effective states: RUN (valid fetch), SQUASH (one bubble after redirect), HOLD (stall); SQUASH → RUN on next non-stalled edge.

## Timing
- Reset (async assert, sync-to-clk deassert assumed externally): PC=RESET_PC, if_id_instr=NOP, if_id_pc=0, if_id_valid=0, counters=0; redirect=0.
- Fetch latency: word at imem_addr appears on if_id_instr one edge later.
- Taken branch penalty: exactly one bubble; target word in IF/ID two edges after branch enters IF/ID.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately; no pending redirect survives.
- Back-to-back branches impossible: the instruction following a taken branch is always squashed.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_fetch_cnt increments on each edge that loads a valid word; perf_redirect_cnt increments on each edge with redirect=1; both saturate at 32'hFFFFFFFF, hold during stall.
- Undefined: both ports exist and are tied to 0; no counter flops.

## Structure
- cpu_pkg: ADDR_W default, INSTR_W=32, NOP_INSTR constant, imm field bit-position localparams.
- One sub-module: branch_target (combinational sign-extend, shift, add; inputs instr, pc, uncond_br; output target).

## Test plan
- Reset with RESET_PC=0, release, imem returns 32'hAAAA0000 at 0 → after 1 edge if_id_instr=AAAA0000, if_id_pc=0, valid=1, imem_addr=4.
- B with imm26=3 in IF/ID at pc 8, br_taken=1, uncond_br=1 → redirect=1, next PC=20, if_id_valid=0, instr=NOP.
- CBZ imm19=0x7FFFE at pc 0x10, br_taken=1, uncond_br=0 → next PC=0x08.
- stall=1 with br_taken=1 for 3 cycles → PC, if_id_* frozen, redirect=0; stall drops → redirect fires.
- PC=2^64−4, no branch → PC wraps to 0; B imm26=−1 at pc 0 → target 2^64−4.
- FETCH_PERF_CNT_EN: 5 fetches, 1 taken branch, 2 stall cycles → perf_fetch_cnt=5, perf_redirect_cnt=1; reset mid-run → both 0.
